// File: rtl/frame_rd_pkg.sv
// frame_rd_pkg: shared FSM states and AXI read encodings for frame_memory_reader
package frame_rd_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, DRAIN} state_e;
  localparam int BYTES_PER_BEAT = 4;
  localparam logic [1:0] BURST_INCR = 2'b01;
  function automatic logic [2:0] size_enc(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
  localparam logic [2:0] SIZE_ENC = size_enc(8 * BYTES_PER_BEAT);
endpackage

// File: rtl/frame_memory_reader_fifo.sv
// sync_fifo: single-clock FIFO with registered head-of-queue output
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic [AW:0]           count_o
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic full, do_push, do_pop;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = dout_q;
  // pointer/count update; the head register picks up data written this cycle when it becomes the head
  always_comb begin
    do_pop = pop_i && (!empty_o || push_i);
    do_push = push_i && (!full || pop_i);
    rd_d = rd_q + AW'(do_pop);
    wr_d = wr_q + AW'(do_push);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_d = (do_push && wr_q == rd_d) ? din_i : mem[rd_d];
  end
  // storage array, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din_i;
  // control state; the writer reserves space, so a lone push into a full FIFO is a design bug
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
    end else begin
      assert (!(push_i && full && !pop_i));
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
    end
endmodule

// File: rtl/frame_memory_reader.sv
// frame_memory_reader: reads a stored frame in line-bounded INCR bursts and replays it as a pixel stream
module frame_memory_reader import frame_rd_pkg::*; #(
  parameter int DATA_WIDTH = 8 * BYTES_PER_BEAT,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_valid,
  input  logic                  read_last,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_overrun
);
  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic pend_v_q, pend_v_d, ovr_q, ovr_d;
  logic [ADDR_WIDTH-1:0] pend_base_q, pend_base_d, addr_q, addr_d;
  logic [15:0] pend_w_q, pend_w_d, pend_h_q, pend_h_d, w_q, w_d, h_q, h_d;
  logic [15:0] rem_q, rem_d, lines_q, lines_d, blen_q, blen_d, col_q, col_d, line_q, line_d;
  logic [15:0] blen;
  logic [CW-1:0] fifo_count;
  logic accept, take, push, pop, fifo_empty;
  assign start_read = state_q == REQ;
  assign read_addr = addr_q;
  assign read_len = start_read ? 32'(blen_q) - 32'd1 : '0;
  assign read_size = size_enc(DATA_WIDTH);
  assign read_burst = BURST_INCR;
  assign read_ready = state_q == DATA;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DRAIN && line_q == h_q;
  assign frame_overrun = ovr_q;
  assign push = read_ready && read_valid;
  assign m_axis_tvalid = !fifo_empty;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast = m_axis_tvalid && col_q == w_q - 16'd1;
  assign m_axis_tuser = m_axis_tvalid && col_q == '0 && line_q == '0;
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .din_i(read_data), .pop_i(pop),
    .dout_o(m_axis_tdata), .empty_o(fifo_empty), .count_o(fifo_count)
  );
  // pending-frame slot, burst sequencing and output framing counters
  always_comb begin
    state_d = state_q;
    pend_base_d = pend_base_q;
    pend_w_d = pend_w_q;
    pend_h_d = pend_h_q;
    addr_d = addr_q;
    w_d = w_q;
    h_d = h_q;
    rem_d = rem_q;
    lines_d = lines_q;
    blen_d = blen_q;
    col_d = col_q;
    line_d = line_q;
    accept = frame_ready && frame_width != '0 && frame_height != '0;
    take = state_q == IDLE && pend_v_q;
    pend_v_d = accept || (pend_v_q && !take);
    ovr_d = accept && pend_v_q && !take;
    blen = rem_q > 16'(MAX_BURST) ? 16'(MAX_BURST) : rem_q;
    if (accept) begin
      pend_base_d = base_addr_in;
      pend_w_d = frame_width;
      pend_h_d = frame_height;
    end
    if (pop) begin
      col_d = m_axis_tlast ? '0 : col_q + 16'd1;
      line_d = line_q + 16'(m_axis_tlast);
    end
    case (state_q)
      IDLE: if (pend_v_q) begin
        addr_d = pend_base_q;
        w_d = pend_w_q;
        h_d = pend_h_q;
        rem_d = pend_w_q;
        lines_d = pend_h_q;
        col_d = '0;
        line_d = '0;
        state_d = WAIT_SPACE;
      end
      WAIT_SPACE: if (32'(FIFO_DEPTH) - 32'(fifo_count) >= 32'(blen)) begin
        blen_d = blen;
        state_d = REQ;
      end
      REQ: state_d = DATA;
      DATA: if (read_valid && read_last) begin
        addr_d = addr_q + (ADDR_WIDTH'(blen_q) << SZ);
        rem_d = rem_q == blen_q ? w_q : rem_q - blen_q;
        lines_d = lines_q - 16'(rem_q == blen_q);
        state_d = (rem_q == blen_q && lines_q == 16'd1) ? DRAIN : WAIT_SPACE;
      end
      DRAIN: if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state register; reset abandons any frame and pending request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pend_v_q <= 1'b0;
      ovr_q <= 1'b0;
      pend_base_q <= '0;
      pend_w_q <= '0;
      pend_h_q <= '0;
      addr_q <= '0;
      w_q <= '0;
      h_q <= '0;
      rem_q <= '0;
      lines_q <= '0;
      blen_q <= '0;
      col_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      pend_v_q <= pend_v_d;
      ovr_q <= ovr_d;
      pend_base_q <= pend_base_d;
      pend_w_q <= pend_w_d;
      pend_h_q <= pend_h_d;
      addr_q <= addr_d;
      w_q <= w_d;
      h_q <= h_d;
      rem_q <= rem_d;
      lines_q <= lines_d;
      blen_q <= blen_d;
      col_q <= col_d;
      line_q <= line_d;
    end
endmodule
